// File: rtl/distance_bcd_conv.sv
// distance_bcd_conv
// Sequential binary-to-BCD converter for the telemetry distance path.
// Converts one bit per clock using shift-and-add-3 (double dabble) into a
// 12-bit scratch of three BCD digits. The result drives three seven-segment
// digit decoders directly.
//
// Optional feature macro: BCD_OVF_FLAG_EN
//   defined     : inputs above 999 produce F,F,F with Ovf=1 (error glyph)
//   not defined : inputs above 999 saturate to 9,9,9 and Ovf is tied to 0

module distance_bcd_conv #(
   parameter int WIDTH = 10
) (
   input  logic             Clk,
   input  logic             nReset,
   input  logic             Start,
   input  logic [WIDTH-1:0] Bin,
   output logic             Busy,
   output logic             Done,
   output logic [3:0]       Bcd2,
   output logic [3:0]       Bcd1,
   output logic [3:0]       Bcd0,
   output logic             Ovf
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t state;
   state_t state_next;

   logic [WIDTH-1:0] shift_reg;
   logic [11:0]      scratch;
   logic [CNT_W-1:0] count;
   logic             ovf_pend;

   logic             accept;
   logic             last_shift;
   logic             ovf_in;
   logic [16:0]      bin_ext;
   logic [11:0]      scratch_adj;
   logic [11:0]      scratch_shifted;
   logic [WIDTH-1:0] shift_next;

   // Add-3 correction for one BCD digit; 4-bit wrap is harmless because
   // only overflowing inputs can push a digit past 9.
   function automatic logic [3:0] adjust_digit(input logic [3:0] d);
      adjust_digit = (d >= 4'd5) ? 4'(d + 4'd3) : d;
   endfunction

   // Decode handshake conditions and the overflow test on the raw input.
   always_comb begin
      accept     = (state == IDLE) && Start;
      last_shift = (state == SHIFT) && (count == '0);
      bin_ext    = 17'(Bin);
      ovf_in     = (bin_ext > 17'd999);
   end

   // One double-dabble step: correct every digit, then shift the combined
   // {scratch, shift_reg} left by one, pulling in the shift register MSB.
   // The carry out of the hundreds digit is intentionally dropped.
   always_comb begin
      scratch_adj     = {adjust_digit(scratch[11:8]),
                         adjust_digit(scratch[7:4]),
                         adjust_digit(scratch[3:0])};
      scratch_shifted = 12'({scratch_adj, shift_reg[WIDTH-1]});
      shift_next      = {shift_reg[WIDTH-2:0], 1'b0};
   end

   // State register.
   always_ff @(posedge Clk or negedge nReset) begin
      if (!nReset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic: Start only matters in IDLE, DONE always lasts one cycle.
   always_comb begin
      state_next = state;
      unique case (state)
         IDLE: begin
            if (accept) begin
               state_next = SHIFT;
            end
         end
         SHIFT: begin
            if (last_shift) begin
               state_next = DONE;
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Status outputs decoded from the registered state only.
   always_comb begin
      Busy = 1'b0;
      Done = 1'b0;
      unique case (state)
         IDLE:    Busy = 1'b0;
         SHIFT:   Busy = 1'b1;
         DONE: begin
            Busy = 1'b1;
            Done = 1'b1;
         end
         default: Busy = 1'b0;
      endcase
   end

   // Conversion datapath: load on accept, step once per SHIFT edge.
   always_ff @(posedge Clk or negedge nReset) begin
      if (!nReset) begin
         shift_reg <= '0;
         scratch   <= '0;
         count     <= '0;
         ovf_pend  <= 1'b0;
      end else if (accept) begin
         shift_reg <= Bin;
         scratch   <= '0;
         count     <= CNT_LAST;
         ovf_pend  <= ovf_in;
      end else if (state == SHIFT) begin
         shift_reg <= shift_next;
         scratch   <= scratch_shifted;
         if (count != '0) begin
            count <= count - CNT_W'(1);
         end
      end
   end

`ifdef BCD_OVF_FLAG_EN
   logic ovf_reg;

   // Result register: loads only on the final shift, error glyph on overflow.
   always_ff @(posedge Clk or negedge nReset) begin
      if (!nReset) begin
         Bcd2    <= 4'd0;
         Bcd1    <= 4'd0;
         Bcd0    <= 4'd0;
         ovf_reg <= 1'b0;
      end else if (last_shift) begin
         if (ovf_pend) begin
            Bcd2    <= 4'hF;
            Bcd1    <= 4'hF;
            Bcd0    <= 4'hF;
            ovf_reg <= 1'b1;
         end else begin
            Bcd2    <= scratch_shifted[11:8];
            Bcd1    <= scratch_shifted[7:4];
            Bcd0    <= scratch_shifted[3:0];
            ovf_reg <= 1'b0;
         end
      end
   end

   assign Ovf = ovf_reg;
`else
   // Result register: loads only on the final shift, saturates on overflow.
   always_ff @(posedge Clk or negedge nReset) begin
      if (!nReset) begin
         Bcd2 <= 4'd0;
         Bcd1 <= 4'd0;
         Bcd0 <= 4'd0;
      end else if (last_shift) begin
         if (ovf_pend) begin
            Bcd2 <= 4'd9;
            Bcd1 <= 4'd9;
            Bcd0 <= 4'd9;
         end else begin
            Bcd2 <= scratch_shifted[11:8];
            Bcd1 <= scratch_shifted[7:4];
            Bcd0 <= scratch_shifted[3:0];
         end
      end
   end

   assign Ovf = 1'b0;
`endif

endmodule

// File: tb/tb_distance_bcd_conv.sv
// tb_distance_bcd_conv
// Self-checking bench for distance_bcd_conv (WIDTH=10). Expected values come
// from constant tables and a div/mod reference model. Honors BCD_OVF_FLAG_EN.

module tb_distance_bcd_conv;

   localparam int WIDTH = 10;
   localparam int TIMEOUT = 3 * WIDTH;

`ifdef BCD_OVF_FLAG_EN
   localparam logic [3:0] OVF_DIG = 4'hF;
   localparam logic       OVF_BIT = 1'b1;
`else
   localparam logic [3:0] OVF_DIG = 4'h9;
   localparam logic       OVF_BIT = 1'b0;
`endif

   logic             clk;
   logic             n_reset;
   logic             start;
   logic [WIDTH-1:0] bin;
   logic             busy;
   logic             done;
   logic [3:0]       bcd2;
   logic [3:0]       bcd1;
   logic [3:0]       bcd0;
   logic             ovf;

   int total;
   int bad;

   typedef struct {
      int         value;
      logic [3:0] d2;
      logic [3:0] d1;
      logic [3:0] d0;
      logic       ovf;
   } vec_t;

   vec_t vecs[12];

   distance_bcd_conv #(.WIDTH(WIDTH)) dut (
      .Clk    (clk),
      .nReset (n_reset),
      .Start  (start),
      .Bin    (bin),
      .Busy   (busy),
      .Done   (done),
      .Bcd2   (bcd2),
      .Bcd1   (bcd1),
      .Bcd0   (bcd0),
      .Ovf    (ovf)
   );

   // 100 MHz clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference: decimal digits by plain division, overflow handled by build
   function automatic logic [12:0] ref_conv(input int v);
      if (v > 999) begin
         ref_conv = {OVF_BIT, OVF_DIG, OVF_DIG, OVF_DIG};
      end else begin
         ref_conv = {1'b0, 4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
      end
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] got,
                              input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s got=%0h expected=%0h", name, got, exp);
      end
   endtask

   // Run one conversion from IDLE; returns outputs and edges-to-Done
   task automatic applyStimulus(input int value, output logic [12:0] result,
                                output int edges);
      int k;
      int guard;
      guard = 0;
      while (busy && guard < TIMEOUT) begin
         @(negedge clk);
         guard++;
      end
      start = 1'b1;
      bin   = WIDTH'(value);
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      bin   = WIDTH'($urandom);
      k = 0;
      while (!done && k <= TIMEOUT) begin
         @(negedge clk);
         k++;
      end
      edges  = k;
      result = {ovf, bcd2, bcd1, bcd0};
      if (!done) begin
         checkOutput("done_timeout", 32'(k), 32'(WIDTH));
      end else begin
         @(negedge clk);
         checkOutput("done_one_cycle", {31'd0, done}, 32'd0);
      end
   endtask

   initial begin
      logic [12:0] res;
      int          edges;
      int          done_cnt;
      int          changes;
      int          last_done;
      int          nres;
      logic [12:0] held;
      int          seq_vals[3];
      logic [12:0] seq_exp[3];

      total   = 0;
      bad     = 0;
      start   = 1'b0;
      bin     = '0;
      n_reset = 1'b0;

      vecs[0]  = '{679,  4'd6, 4'd7, 4'd9, 1'b0};
      vecs[1]  = '{0,    4'd0, 4'd0, 4'd0, 1'b0};
      vecs[2]  = '{999,  4'd9, 4'd9, 4'd9, 1'b0};
      vecs[3]  = '{1000, OVF_DIG, OVF_DIG, OVF_DIG, OVF_BIT};
      vecs[4]  = '{1023, OVF_DIG, OVF_DIG, OVF_DIG, OVF_BIT};
      vecs[5]  = '{45,   4'd0, 4'd4, 4'd5, 1'b0};
      vecs[6]  = '{5,    4'd0, 4'd0, 4'd5, 1'b0};
      vecs[7]  = '{99,   4'd0, 4'd9, 4'd9, 1'b0};
      vecs[8]  = '{100,  4'd1, 4'd0, 4'd0, 1'b0};
      vecs[9]  = '{512,  4'd5, 4'd1, 4'd2, 1'b0};
      vecs[10] = '{250,  4'd2, 4'd5, 4'd0, 1'b0};
      vecs[11] = '{1,    4'd0, 4'd0, 4'd1, 1'b0};

      // Reset state
      repeat (3) @(negedge clk);
      checkOutput("reset_state", {17'd0, busy, done, bcd2, bcd1, bcd0, ovf}, 32'd0);
      n_reset = 1'b1;
      @(negedge clk);

      // Mid-conversion reset clears everything asynchronously, no Done follows
      applyStimulus(123, res, edges);
      checkOutput("pre_reset_result", 32'(res), 32'h0123);
      start = 1'b1;
      bin   = WIDTH'(10'h2A7);
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("busy_before_reset", {31'd0, busy}, 32'd1);
      #2 n_reset = 1'b0;
      #1;
      checkOutput("async_reset_outputs", {17'd0, busy, done, bcd2, bcd1, bcd0, ovf}, 32'd0);
      @(negedge clk);
      n_reset = 1'b1;
      done_cnt = 0;
      for (int i = 0; i < WIDTH + 4; i++) begin
         @(negedge clk);
         if (done) done_cnt++;
      end
      checkOutput("no_done_after_reset", 32'(done_cnt), 32'd0);
      checkOutput("idle_after_reset", {31'd0, busy}, 32'd0);

      // Table-driven vectors with latency check
      for (int i = 0; i < 12; i++) begin
         applyStimulus(vecs[i].value, res, edges);
         checkOutput($sformatf("vec%0d_result_%0d", i, vecs[i].value), 32'(res),
                     32'({vecs[i].ovf, vecs[i].d2, vecs[i].d1, vecs[i].d0}));
         checkOutput($sformatf("vec%0d_latency", i), 32'(edges), 32'(WIDTH));
      end

      // Start while busy: pulses at cycles 3 and 11 after accepting 45
      start = 1'b1;
      bin   = WIDTH'(45);
      @(posedge clk);
      done_cnt = 0;
      nres = 0;
      for (int c = 1; c <= 16; c++) begin
         @(negedge clk);
         if (done) done_cnt++;
         if (c == 13) nres = int'(busy);
         start = (c == 3 || c == 11);
         bin   = (c >= 3) ? WIDTH'(800) : WIDTH'(45);
      end
      start = 1'b0;
      checkOutput("busy_start_single_done", 32'(done_cnt), 32'd1);
      checkOutput("busy_start_not_queued", 32'(nres), 32'd0);
      checkOutput("busy_start_result", {19'd0, ovf, bcd2, bcd1, bcd0}, 32'h045);

      // Continuous Start: Done every WIDTH+2 cycles, outputs stable between
      seq_vals[0] = 100;
      seq_vals[1] = 250;
      seq_vals[2] = 512;
      for (int i = 0; i < 3; i++) seq_exp[i] = ref_conv(seq_vals[i]);
      @(negedge clk);
      start = 1'b1;
      bin   = WIDTH'(seq_vals[0]);
      done_cnt  = 0;
      changes   = 0;
      last_done = -1;
      held = {ovf, bcd2, bcd1, bcd0};
      for (int c = 0; c < 5 * (WIDTH + 2) && done_cnt < 3; c++) begin
         @(negedge clk);
         if (done) begin
            checkOutput($sformatf("cont_result_%0d", done_cnt),
                        32'({ovf, bcd2, bcd1, bcd0}), 32'(seq_exp[done_cnt]));
            if (last_done >= 0)
               checkOutput($sformatf("cont_period_%0d", done_cnt),
                           32'(c - last_done), 32'(WIDTH + 2));
            last_done = c;
            held = {ovf, bcd2, bcd1, bcd0};
            done_cnt++;
            if (done_cnt < 3) bin = WIDTH'(seq_vals[done_cnt]);
         end else if ({ovf, bcd2, bcd1, bcd0} !== held) begin
            changes++;
         end
      end
      start = 1'b0;
      checkOutput("cont_done_count", 32'(done_cnt), 32'd3);
      checkOutput("cont_outputs_stable", 32'(changes), 32'd0);
      repeat (WIDTH + 4) @(negedge clk);

      // Exhaustive sweep against the reference model
      for (int v = 0; v < (1 << WIDTH); v++) begin
         applyStimulus(v, res, edges);
         checkOutput($sformatf("sweep_%0d", v), 32'(res), 32'(ref_conv(v)));
      end

      // Randomized values with random idle gaps
      for (int i = 0; i < 150; i++) begin
         int rv;
         rv = int'($urandom_range(0, (1 << WIDTH) - 1));
         repeat ($urandom_range(0, 2)) @(negedge clk);
         applyStimulus(rv, res, edges);
         checkOutput($sformatf("rand_%0d", rv), 32'(res), 32'(ref_conv(rv)));
         checkOutput($sformatf("rand_latency_%0d", rv), 32'(edges), 32'(WIDTH));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
